// File: rtl/ctrl_pipe_reg.sv
// rtl/ctrl_pipe_reg.sv - control-word pipeline with bubble, hold, flush and per-stage valid
//
// Carries decoded control words from ID through DEPTH registered stages
// (stage 0 = ID/EX). Per edge the action priority is flush > hold > bubble > shift.
// Optional statistics counters are built when CTRL_PIPE_STATS_EN is defined.
//
// Ports:
//   clk_i, rst_i     clock (rising edge), asynchronous active-high reset
//   ctrl_i           control word from the decoder
//   bubble_i         inject NOP into stage 0
//   hold_i           freeze all stages
//   flush_i          kill incoming word and stages 0..FLUSH_STAGES-1
//   ctrl_o           stage k word at [k*CTRL_W +: CTRL_W]
//   valid_o          bit k = stage k holds a real instruction
//   bubble_cnt_o     bubbles inserted (0 without CTRL_PIPE_STATS_EN)
//   flush_cnt_o      flush events (0 without CTRL_PIPE_STATS_EN)
module ctrl_pipe_reg #(
  parameter int                CTRL_W       = 8,
  parameter int                DEPTH        = 3,
  parameter int                FLUSH_STAGES = 1,
  parameter logic [CTRL_W-1:0] NOP_VALUE    = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic                    bubble_i,
  input  logic                    hold_i,
  input  logic                    flush_i,
  output logic [DEPTH*CTRL_W-1:0] ctrl_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic [15:0]             bubble_cnt_o,
  output logic [15:0]             flush_cnt_o
);

  logic [CTRL_W-1:0] stage_q [DEPTH];
  logic [CTRL_W-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    valid_d = valid_q;

    if (flush_i) begin
      // Stage 0 is always killed by a flush (FLUSH_STAGES >= 1).
      stage_d[0] = NOP_VALUE;
      valid_d[0] = 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
        if (hold_i) begin
          // Held flush: only the flushed stages are cleared, the rest stay put.
          if (k < FLUSH_STAGES) begin
            stage_d[k] = NOP_VALUE;
            valid_d[k] = 1'b0;
          end
        end else begin
          // Moving flush: stage FLUSH_STAGES would receive a killed word, so
          // it is cleared too; everything older shifts normally.
          if (k <= FLUSH_STAGES) begin
            stage_d[k] = NOP_VALUE;
            valid_d[k] = 1'b0;
          end else begin
            stage_d[k] = stage_q[k-1];
            valid_d[k] = valid_q[k-1];
          end
        end
      end
    end else if (!hold_i) begin
      stage_d[0] = bubble_i ? NOP_VALUE : ctrl_i;
      valid_d[0] = ~bubble_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= NOP_VALUE;
      end
      valid_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
      valid_q <= valid_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign ctrl_o[g*CTRL_W +: CTRL_W] = stage_q[g];
  end
  assign valid_o = valid_q;

`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] bubble_cnt_q;
  logic [15:0] bubble_cnt_d;
  logic [15:0] flush_cnt_q;
  logic [15:0] flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    // A bubble only counts when it is the action actually taken.
    if (bubble_i && !hold_i && !flush_i && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
    if (flush_i && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_q <= 16'h0000;
      flush_cnt_q  <= 16'h0000;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`else
  assign bubble_cnt_o = 16'h0000;
  assign flush_cnt_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// tb/tb_ctrl_pipe_reg.sv - self-checking bench for ctrl_pipe_reg
module tb_ctrl_pipe_reg;

  localparam int DEPTH = 3;
  localparam int FS    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ctrl = 8'h00;
  logic        bubble = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [23:0] ctrl_o;
  logic [2:0]  valid_o;
  logic [15:0] bubble_cnt_o;
  logic [15:0] flush_cnt_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ctrl_pipe_reg #(
    .CTRL_W(8), .DEPTH(DEPTH), .FLUSH_STAGES(FS), .NOP_VALUE(8'h00)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .bubble_i(bubble), .hold_i(hold),
    .flush_i(flush), .ctrl_o(ctrl_o), .valid_o(valid_o),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the pipe as a queue of entries, newest at the front.
  typedef struct packed {
    logic [7:0] w;
    logic       v;
  } ent_t;

  localparam ent_t NOP_ENT = '{w: 8'h00, v: 1'b0};

  ent_t mq[$];
  int   m_bcnt = 0;
  int   m_fcnt = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  initial begin
    for (int k = 0; k < DEPTH; k++) mq.push_back(NOP_ENT);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) mq[k] = NOP_ENT;
        m_bcnt = 0;
        m_fcnt = 0;
      end else if (flush) begin
        m_fcnt = sat16(m_fcnt + 1);
        if (hold) begin
          for (int k = 0; k < FS; k++) mq[k] = NOP_ENT;
        end else begin
          mq.push_front(NOP_ENT);
          void'(mq.pop_back());
          for (int k = 0; k <= FS; k++) mq[k] = NOP_ENT;
        end
      end else if (!hold) begin
        if (bubble) begin
          m_bcnt = sat16(m_bcnt + 1);
          mq.push_front(NOP_ENT);
        end else begin
          mq.push_front('{w: ctrl, v: 1'b1});
        end
        void'(mq.pop_back());
      end
    end
  end

  function automatic int exp_bcnt();
`ifdef CTRL_PIPE_STATS_EN
    return m_bcnt;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_fcnt();
`ifdef CTRL_PIPE_STATS_EN
    return m_fcnt;
`else
    return 0;
`endif
  endfunction

  // Compare process: DUT against model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          check($sformatf("model_stage%0d_word", k), 32'(ctrl_o[k*8 +: 8]), 32'(mq[k].w));
          check($sformatf("model_stage%0d_valid", k), 32'(valid_o[k]), 32'(mq[k].v));
        end
        check("model_bubble_cnt", 32'(bubble_cnt_o), exp_bcnt());
        check("model_flush_cnt", 32'(flush_cnt_o), exp_fcnt());
      end
    end
  end

  task automatic drive(input logic [7:0] c, input logic b, input logic h, input logic f);
    ctrl = c; bubble = b; hold = h; flush = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Mixed stimulus: {ctrl, bubble, hold, flush}
  typedef struct packed {
    logic [7:0] c;
    logic       b;
    logic       h;
    logic       f;
  } vec_t;

  vec_t vecs [16] = '{
    '{8'h5A, 1'b0, 1'b0, 1'b0}, '{8'h6B, 1'b0, 1'b0, 1'b0}, '{8'h7C, 1'b1, 1'b0, 1'b0},
    '{8'h8D, 1'b0, 1'b0, 1'b0}, '{8'h9E, 1'b0, 1'b1, 1'b1}, '{8'hAF, 1'b1, 1'b1, 1'b0},
    '{8'hB0, 1'b0, 1'b0, 1'b0}, '{8'hC1, 1'b0, 1'b0, 1'b0}, '{8'hD2, 1'b0, 1'b0, 1'b1},
    '{8'hE3, 1'b0, 1'b0, 1'b0}, '{8'hF4, 1'b1, 1'b0, 1'b0}, '{8'h05, 1'b1, 1'b0, 1'b0},
    '{8'h16, 1'b0, 1'b0, 1'b0}, '{8'h27, 1'b0, 1'b1, 1'b0}, '{8'h38, 1'b1, 1'b0, 1'b1},
    '{8'h49, 1'b0, 1'b0, 1'b0}
  };

  logic [31:0] stat_b;
  logic [31:0] stat_f;

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'(ctrl_o), 32'h0);
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_bubble_cnt", 32'(bubble_cnt_o), 32'h0);
    check("reset_flush_cnt", 32'(flush_cnt_o), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Fill: stage2..0 = 11/22/33
    drive(8'h11, 0, 0, 0);
    drive(8'h22, 0, 0, 0);
    drive(8'h33, 0, 0, 0);
    check("fill_ctrl", 32'(ctrl_o), 32'h112233);
    check("fill_valid", 32'(valid_o), 32'b111);

    // Flush: stage0/1 killed, stage2 receives 22
    drive(8'h44, 0, 0, 1);
    check("flush_ctrl", 32'(ctrl_o), 32'h220000);
    check("flush_valid", 32'(valid_o), 32'b100);

    // Bubble after 22, then it moves to stage1
    drive(8'h11, 0, 0, 0);
    drive(8'h22, 0, 0, 0);
    drive(8'h99, 1, 0, 0);
    check("bubble_ctrl", 32'(ctrl_o), 32'h112200);
    check("bubble_valid", 32'(valid_o), 32'b110);
    drive(8'h44, 0, 0, 0);
    check("bubble_move_ctrl", 32'(ctrl_o), 32'h220044);
    check("bubble_move_valid", 32'(valid_o), 32'b101);

    // Hold for 4 edges, ctrl changing, bubble ignored
    for (int i = 0; i < 4; i++) begin
      drive(8'h50 + 8'(i), 1'(i % 2), 1, 0);
      check("hold_ctrl", 32'(ctrl_o), 32'h220044);
      check("hold_valid", 32'(valid_o), 32'b101);
    end

    // Flush during hold: only stage0 cleared
    drive(8'h66, 0, 1, 1);
    check("flush_hold_ctrl", 32'(ctrl_o), 32'h220000);
    check("flush_hold_valid", 32'(valid_o), 32'b100);

    // Flush with bubble, no hold: stage2 receives the NOP from stage1
    drive(8'h77, 1, 0, 1);
    check("flush_bubble_ctrl", 32'(ctrl_o), 32'h000000);
    check("flush_bubble_valid", 32'(valid_o), 32'b000);

    // Mixed vectors checked only by the model
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].c, vecs[i].b, vecs[i].h, vecs[i].f);
    end

    // Mid-stream asynchronous reset with C3/B2/A1 in the pipe
    drive(8'hC3, 0, 0, 0);
    drive(8'hB2, 0, 0, 0);
    drive(8'hA1, 0, 0, 0);
    check("pre_reset_ctrl", 32'(ctrl_o), 32'hC3B2A1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_ctrl", 32'(ctrl_o), 32'h0);
    check("async_reset_valid", 32'(valid_o), 32'h0);
    check("async_reset_bubble_cnt", 32'(bubble_cnt_o), 32'h0);
    check("async_reset_flush_cnt", 32'(flush_cnt_o), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Statistics: 3 bubbles, 2 flushes (one held), 1 flush+bubble
    drive(8'h01, 1, 0, 0);
    drive(8'h02, 0, 0, 0);
    drive(8'h03, 1, 0, 0);
    drive(8'h04, 1, 1, 0);
    drive(8'h05, 1, 0, 0);
    drive(8'h06, 0, 0, 1);
    drive(8'h07, 0, 1, 1);
    drive(8'h08, 1, 0, 1);
`ifdef CTRL_PIPE_STATS_EN
    stat_b = 32'd3;
    stat_f = 32'd3;
`else
    stat_b = 32'd0;
    stat_f = 32'd0;
`endif
    check("stats_bubble_cnt", 32'(bubble_cnt_o), stat_b);
    check("stats_flush_cnt", 32'(flush_cnt_o), stat_f);

`ifdef CTRL_PIPE_STATS_EN
    // Walk the bubble counter to 16'hFFFE, then confirm saturation
    for (int i = 0; i < 65531; i++) begin
      drive(8'h00, 1, 0, 0);
    end
    check("sat_pre_bubble_cnt", 32'(bubble_cnt_o), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, 1, 0, 0);
    end
    check("sat_bubble_cnt", 32'(bubble_cnt_o), 32'hFFFF);
`endif

    drive(8'h00, 0, 0, 0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
